run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Sequences the single-cycle MIPS datapath: loads a program into instruction memory over a valid/ready stream, holds the datapath in reset while loading, then runs, single-steps or halts it.
- Gates datapath state updates through a clock enable, detects a halt instruction and counts executed cycles.
- Sits between the testbench/host command interface and the datapath, program counter and instruction memory write port.

Parameters:
- IMEM_BYTES, 256, instruction memory size in bytes; word-aligned addressing, power of two, at least 8.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops execution.
- CNT_W, 32, width of cycle_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_load  input  1  single-cycle pulse: start program load.
- cmd_run  input  1  single-cycle pulse: free-run.
- cmd_step  input  1  single-cycle pulse: execute one instruction.
- cmd_halt  input  1  single-cycle pulse: stop or abort.
- load_valid  input  1  load_data valid.
- load_data  input  32  program word.
- load_last  input  1  final word of program, qualified by load_valid.
- load_ready  output  1  controller accepts a word.
- instruction  input  32  instruction currently fetched by the datapath.
- imem_we  output  1  instruction memory write enable.
- imem_waddr  output  log2(IMEM_BYTES)  byte write address, low 2 bits always 0.
- imem_wdata  output  32  write data.
- cpu_reset  output  1  active-high reset to the datapath and program counter.
- cpu_en  output  1  enables PC, register file and data memory updates this cycle.
- halted  output  1  high in HALTED state.
- state  output  3  encoded state, for debug.
- cycle_count  output  CNT_W  number of cycles with cpu_en=1.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4.
- cpu_reset is 1 in IDLE and LOAD and 0 otherwise. It is derived from registered state only.
- Asynchronous reset, at any time including mid-load or mid-run:
  - state=IDLE, cpu_reset=1, cpu_en=0, load_ready=0, imem_we=0, halted=0.
  - Load address counter=0, cycle_count=0.
- Command priority when several pulse together: halt > load > step > run.
- IDLE:
  - cmd_load -> LOAD, address counter cleared.
  - cmd_step -> STEP, cycle_count cleared.
  - cmd_run -> RUN, cycle_count cleared.
  - cmd_halt -> no effect.
- LOAD:
  - load_ready=1.
  - imem_we = load_valid & load_ready, combinational and same cycle; imem_waddr=counter, imem_wdata=load_data.
  - Each accepted word advances the counter by 4.
  - Accepted word with load_last=1, or accepted word at address IMEM_BYTES-4 -> IDLE next cycle. The counter does not wrap and no further writes occur.
  - cmd_halt -> IDLE and the current word is not written. Other commands are ignored.
- cpu_en = (state==RUN or state==STEP) and instruction!=HALT_WORD and !cmd_halt. This is combinational, so a halt word is never executed.
- RUN:
  - Halt word fetched, or cmd_halt -> HALTED next cycle.
  - cmd_load -> LOAD. Other commands are ignored.
- STEP: exactly one cycle in this state, then HALTED unconditionally.
- HALTED:
  - cpu_reset=0, so architectural state is preserved. cpu_en=0, halted=1.
  - cmd_run -> RUN and cmd_step -> STEP, but only if instruction!=HALT_WORD; otherwise ignored.
  - cmd_load -> LOAD. cmd_halt has no effect.
- cycle_count increments on every cycle with cpu_en=1, saturates at all-ones, and clears only on the IDLE->RUN/STEP transition and on reset.
- Entering LOAD from RUN or HALTED asserts cpu_reset from the next cycle.

Test Plan:
- Reset held low for 3 cycles, then released -> state=0, cpu_reset=1, cpu_en=0, load_ready=0, cycle_count=0.
- cmd_load, then 4 words 0x20080001..0x20080004 with valid gapped every other cycle, last on word 4 -> writes to addresses 0,4,8,12 only on valid cycles; IDLE after word 4.
- Load IMEM_BYTES/4+2 words with load_last never set -> exactly 64 writes, last at 0xFC; return to IDLE; load_ready=0 afterwards.
- Load 3 instructions plus HALT_WORD, then cmd_run -> cpu_en high for 3 cycles, low on the halt word; HALTED; cycle_count=3; subsequent cmd_run ignored.
- From HALTED on a non-halt instruction, issue cmd_step twice -> cpu_en high for exactly 1 cycle each; cycle_count +1 each; return to HALTED.
- During RUN, cmd_halt and cmd_load in the same cycle -> cpu_en=0 that cycle, next state HALTED. Then reset low mid-run -> immediate IDLE, cpu_reset=1.

Source files
------------

// File: rtl/run_controller.sv
// run_controller: loads instruction memory, then runs, single-steps or halts a single-cycle MIPS datapath.
module run_controller #(
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int          CNT_W      = 32,
    localparam int         AW         = $clog2(IMEM_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic [31:0]      instruction,
    output logic             imem_we,
    output logic [AW-1:0]    imem_waddr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, STEP = 3'd3, HALTED = 3'd4} state_t;
    state_t curState, nextState;
    logic [AW-1:0] addrCnt;
    logic haltWord, lastAddr;
    assign haltWord    = instruction == HALT_WORD;
    assign lastAddr    = addrCnt == AW'(IMEM_BYTES - 4);
    // a halt pulse aborts the load without accepting the word on the bus
    assign load_ready  = curState == LOAD && !cmd_halt;
    assign imem_we     = load_valid && load_ready;
    assign imem_waddr  = addrCnt;
    assign imem_wdata  = load_data;
    assign cpu_reset   = curState == IDLE || curState == LOAD;
    assign cpu_en      = (curState == RUN || curState == STEP) && !haltWord && !cmd_halt;
    assign halted      = curState == HALTED;
    assign state       = curState;
    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:    nextState = cmd_halt ? IDLE : cmd_load ? LOAD : cmd_step ? STEP : cmd_run ? RUN : IDLE;
            LOAD:    nextState = (cmd_halt || (imem_we && (load_last || lastAddr))) ? IDLE : LOAD;
            RUN:     nextState = (cmd_halt || haltWord) ? HALTED : cmd_load ? LOAD : RUN;
            STEP:    nextState = HALTED;
            HALTED:  nextState = cmd_halt ? HALTED : cmd_load ? LOAD : haltWord ? HALTED :
                                 cmd_step ? STEP : cmd_run ? RUN : HALTED;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState    <= IDLE;
            addrCnt     <= '0;
            cycle_count <= '0;
        end else begin
            curState <= nextState;
            if (curState != LOAD && nextState == LOAD)
                addrCnt <= '0;
            else if (imem_we && !lastAddr)
                addrCnt <= addrCnt + AW'(4);
            if (curState == IDLE && (nextState == RUN || nextState == STEP))
                cycle_count <= '0;
            else if (cpu_en && !(&cycle_count))
                cycle_count <= cycle_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: table vectors, directed multi-cycle sequences and random traffic against a reference model.
module tb_run_controller;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int IDLE = 0, LOAD = 1, RUN = 2, STEP = 3, HALTED = 4;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic clk = 0, reset = 0;
    logic cmd_load = 0, cmd_run = 0, cmd_step = 0, cmd_halt = 0;
    logic load_valid = 0, load_last = 0, load_ready;
    logic [31:0] load_data = 0, instruction, imem_wdata;
    logic imem_we, cpu_reset, cpu_en, halted;
    logic [7:0] imem_waddr;
    logic [2:0] state;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    run_controller dut (
        .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_step(cmd_step),
        .cmd_halt(cmd_halt), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .instruction(instruction), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .halted(halted),
        .state(state), .cycle_count(cycle_count)
    );

    // environment: instruction memory plus program counter of the datapath
    logic [31:0] imem [64];
    int pc = 0;
    logic useMem = 0;
    logic [31:0] instrDrive = 0;
    always @(posedge clk) begin
        if (imem_we) imem[imem_waddr[7:2]] <= imem_wdata;
        if (cpu_reset) pc <= 0;
        else if (cpu_en) pc <= pc + 1;
    end
    assign instruction = useMem ? imem[pc % 64] : instrDrive;

    int checks = 0, errors = 0;
    int mSt = IDLE, mAddr = 0;
    longint mCnt = 0;
    logic sH, sL, sS, sR, sV, sLast, sHw, sEn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mSt = IDLE; mAddr = 0; mCnt = 0;
    endtask

    task automatic checkOutputs();
        logic expReady, expWe;
        {sH, sL, sS, sR, sV, sLast} = {cmd_halt, cmd_load, cmd_step, cmd_run, load_valid, load_last};
        sHw = instruction === HALT;
        expReady = mSt == LOAD && !sH;
        expWe = expReady && sV;
        sEn = (mSt == RUN || mSt == STEP) && !sHw && !sH;
        chk("state", state, mSt);
        chk("cpu_reset", cpu_reset, mSt == IDLE || mSt == LOAD);
        chk("cpu_en", cpu_en, sEn);
        chk("load_ready", load_ready, expReady);
        chk("imem_we", imem_we, expWe);
        chk("halted", halted, mSt == HALTED);
        chk("cycle_count", cycle_count, mCnt);
        if (expWe) begin
            chk("imem_waddr", imem_waddr, mAddr);
            chk("imem_wdata", imem_wdata, load_data);
        end
    endtask

    task automatic modelUpdate();
        if (!reset) modelReset();
        else begin
            if (sEn && mCnt < MAXC) mCnt++;
            case (mSt)
                IDLE:
                    if (sH) ;
                    else if (sL) begin mSt = LOAD; mAddr = 0; end
                    else if (sS) begin mSt = STEP; mCnt = 0; end
                    else if (sR) begin mSt = RUN; mCnt = 0; end
                LOAD:
                    if (sH) mSt = IDLE;
                    else if (sV) begin
                        if (sLast || mAddr == 252) mSt = IDLE;
                        if (mAddr != 252) mAddr += 4;
                    end
                RUN:
                    if (sH || sHw) mSt = HALTED;
                    else if (sL) begin mSt = LOAD; mAddr = 0; end
                STEP: mSt = HALTED;
                default:
                    if (sH) ;
                    else if (sL) begin mSt = LOAD; mAddr = 0; end
                    else if (!sHw && sS) mSt = STEP;
                    else if (!sHw && sR) mSt = RUN;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic setIn(input logic [3:0] c, input logic v, input logic [31:0] d, input logic l);
        {cmd_halt, cmd_load, cmd_step, cmd_run} = c;
        load_valid = v; load_data = d; load_last = l;
    endtask

    typedef struct {
        logic [3:0] cmd; logic valid; logic [31:0] data; logic last;
        logic [2:0] st; logic we; logic [7:0] addr;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int writes, lastW, enCnt;
        logic [31:0] prog[4];
        for (int i = 0; i < 64; i++) imem[i] = 0;
        // cmd = {halt, load, step, run}
        vecs[0] = '{4'b0100, 0, 32'h0,        0, 3'd0, 0, 8'd0};
        vecs[1] = '{4'b0000, 1, 32'h20080001, 0, 3'd1, 1, 8'd0};
        vecs[2] = '{4'b0000, 0, 32'h0,        0, 3'd1, 0, 8'd0};
        vecs[3] = '{4'b0000, 1, 32'h20080002, 0, 3'd1, 1, 8'd4};
        vecs[4] = '{4'b0000, 0, 32'h0,        0, 3'd1, 0, 8'd0};
        vecs[5] = '{4'b0000, 1, 32'h20080003, 0, 3'd1, 1, 8'd8};
        vecs[6] = '{4'b0000, 0, 32'h0,        0, 3'd1, 0, 8'd0};
        vecs[7] = '{4'b0000, 1, 32'h20080004, 1, 3'd1, 1, 8'd12};
        vecs[8] = '{4'b0000, 0, 32'h0,        0, 3'd0, 0, 8'd0};

        repeat (3) @(posedge clk);
        modelReset();
        #1;
        chk("rst state", state, 0);
        chk("rst cpu_reset", cpu_reset, 1);
        chk("rst cpu_en", cpu_en, 0);
        chk("rst load_ready", load_ready, 0);
        chk("rst imem_we", imem_we, 0);
        chk("rst halted", halted, 0);
        chk("rst cycle_count", cycle_count, 0);
        reset = 1;

        foreach (vecs[i]) begin
            setIn(vecs[i].cmd, vecs[i].valid, vecs[i].data, vecs[i].last);
            #1;
            chk("vec state", state, vecs[i].st);
            chk("vec imem_we", imem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk("vec waddr", imem_waddr, vecs[i].addr);
                chk("vec wdata", imem_wdata, vecs[i].data);
            end
            tick();
        end

        setIn(4'b0100, 0, 0, 0); tick();
        writes = 0; lastW = -1;
        for (int i = 0; i < 66; i++) begin
            setIn(4'b0000, 1, 32'h1000 + i, 0);
            #1;
            if (imem_we) begin writes++; lastW = imem_waddr; end
            tick();
        end
        setIn(4'b0000, 0, 0, 0);
        #1;
        chk("full writes", writes, 64);
        chk("full last addr", lastW, 8'hFC);
        chk("full state", state, IDLE);
        chk("full load_ready", load_ready, 0);

        prog = '{32'h20080001, 32'h20080002, 32'h20080003, HALT};
        setIn(4'b0100, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin setIn(4'b0000, 1, prog[i], i == 3); tick(); end
        useMem = 1;
        setIn(4'b0001, 0, 0, 0); tick();
        enCnt = 0;
        for (int i = 0; i < 6; i++) begin setIn(4'b0000, 0, 0, 0); #1; if (cpu_en) enCnt++; tick(); end
        chk("run en cycles", enCnt, 3);
        chk("run halted state", state, HALTED);
        chk("run cycle_count", cycle_count, 3);
        setIn(4'b0001, 0, 0, 0); tick();
        setIn(4'b0000, 0, 0, 0); #1;
        chk("run on halt word ignored", state, HALTED);

        useMem = 0; instrDrive = 32'h20080005;
        for (int s = 0; s < 2; s++) begin
            setIn(4'b0010, 0, 0, 0); tick();
            enCnt = 0;
            for (int i = 0; i < 3; i++) begin setIn(4'b0000, 0, 0, 0); #1; if (cpu_en) enCnt++; tick(); end
            chk("step en cycles", enCnt, 1);
            chk("step count", cycle_count, 4 + s);
            chk("step state", state, HALTED);
        end

        setIn(4'b0001, 0, 0, 0); tick();
        setIn(4'b0000, 0, 0, 0); tick(); tick();
        setIn(4'b1100, 0, 0, 0); #1;
        chk("halt+load en", cpu_en, 0);
        tick();
        setIn(4'b0000, 0, 0, 0); #1;
        chk("halt+load state", state, HALTED);
        setIn(4'b0001, 0, 0, 0); tick();
        setIn(4'b0000, 0, 0, 0); tick();
        #1 reset = 0;
        #1;
        chk("async rst state", state, IDLE);
        chk("async rst cpu_reset", cpu_reset, 1);
        chk("async rst cpu_en", cpu_en, 0);
        chk("async rst count", cycle_count, 0);
        modelReset();
        tick();
        reset = 1;

        for (int i = 0; i < 800; i++) begin
            setIn({$urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0}, 1'($urandom), $urandom, $urandom_range(0, 7) == 0);
            instrDrive = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
            if ($urandom_range(0, 149) == 0) begin
                reset = 0; #1; modelReset(); tick(); reset = 1;
            end else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
